sr_hypot_unit: RTL and testbench
================================

// Module: sr_hypot_unit
// PURPOSE
//   Multi-cycle arithmetic unit computing y = floor(sqrt(a*a + b*b)) for unsigned operands.
//   Sits beside the ALU in sr_cpu and is driven by the control unit's start/busy handshake
//   for the custom HYPO instruction. Result is written back to rd via the wd3 mux.
//   Uses a shift-add multiplier and a restoring bit-serial square root, one bit per cycle.
// PARAMETERS
//   DATA_W   8   operand width; result is DATA_W+1 bits; radicand is 2*DATA_W+1 bits
// PORTS
//   clk    in   1           clock, all state updates on rising edge
//   rst_n  in   1           synchronous active-low reset
//   start  in   1           request; sampled only when busy==0
//   a      in   DATA_W      operand A (rs1 low bits), captured on accepted start
//   b      in   DATA_W      operand B (rs2 low bits), captured on accepted start
//   y      out  DATA_W+1    result; holds last value until next completion
//   busy   out  1           registered; high while a computation is in flight
// BEHAVIOUR
//   Reset: rst_n==0 at a clock edge -> state=IDLE, busy=0, y=0, all internal regs 0.
//     Mid-operation reset aborts the computation; no result is written.
//   States: IDLE -> SQA -> SQB -> ROOT -> IDLE.
//   IDLE: if start && !busy at edge: latch a,b; clear acc; cnt=0; go SQA; busy<=1.
//     start while busy (any non-IDLE state) is ignored; no re-latch, no restart.
//   SQA: acc += (a_r[cnt] ? a_r<<cnt : 0); cnt++. After DATA_W cycles go SQB, cnt=0.
//   SQB: same with b_r, accumulating into acc. After DATA_W cycles acc = a^2+b^2; go ROOT.
//     acc width 2*DATA_W+1; max for DATA_W=8 is 130050 (no overflow by construction).
//   ROOT: restoring sqrt, DATA_W+1 iterations, MSB first: trial = (root|bit)^2 compare
//     realised as rem/root shift-subtract; on non-negative result keep bit. One bit/cycle.
//     On the last iteration edge: y<=root, busy<=0, state<=IDLE.
//   Latency: busy high for exactly 3*DATA_W+1 cycles (25 for DATA_W=8) after the accepting
//     edge; y valid and stable on the first cycle busy is low.
//   Back-to-back: start high on the first cycle busy==0 is accepted on that edge.
//   y changes only at a completion edge or reset; never glitches during computation.
//   No combinational path from start/a/b to busy or y (avoids loop via control unit).
// TESTING
//   a=3,b=4, start 1 cycle -> busy high 25 cycles, then y=5, busy=0.
//   a=5,b=12 -> y=13; a=0,b=0 -> y=0; a=1,b=1 -> y=1 (floor of 1.414).
//   a=255,b=255 -> y=360 (max radicand 130050, no overflow).
//   start=1 with a=7,b=24 at cycle 10 of a 3/4 job -> ignored; y=5 at completion.
//   rst_n=0 at cycle 12 of a job -> next cycle busy=0, y=0; new start a=6,b=8 -> y=10.
//   Hold start=1 continuously with changing a,b -> each job latches operands at its
//   accepting edge; consecutive results 26 cycles apart, each matches its own operands.

Source files
------------

// File: rtl/sr_hypot_unit.sv
// sr_hypot_unit: multi-cycle y = floor(sqrt(a*a + b*b)) for unsigned operands.
// Ports: clk, rst_n (sync, active-low), start/busy handshake, a, b in; y result out.
module sr_hypot_unit #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W:0]   y,
    output logic              busy
);

    // Top bit of acc pads the radicand to an even width for the 2-bit/iter root.
    localparam int ACC_W = 2 * DATA_W + 2;
    localparam int REM_W = DATA_W + 4;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_SQ = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_RT = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQA  = 2'd1,
        SQB  = 2'd2,
        ROOT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [DATA_W:0]   root_q, root_d;
    logic [DATA_W:0]   y_q, y_d;
    logic              busy_q, busy_d;

    logic [IDX_W-1:0]  idx;
    logic [REM_W-1:0]  rem_t;
    logic [REM_W-1:0]  trial;
    logic              ge;

    always_comb begin
        idx   = cnt_q[IDX_W-1:0];
        // Next two radicand bits shifted into the partial remainder.
        rem_t = {rem_q[REM_W-3:0], acc_q[ACC_W-1 -: 2]};
        // (2*root + 1) scaled to the current bit position: {root, 01}.
        trial = REM_W'({root_q, 2'b01});
        ge    = (rem_t >= trial);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        root_d  = root_q;
        y_d     = y_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    rem_d   = '0;
                    root_d  = '0;
                    busy_d  = 1'b1;
                    state_d = SQA;
                end
            end
            SQA: begin
                acc_d = acc_q + (a_q[idx] ? (ACC_W'(a_q) << cnt_q) : '0);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_SQ) begin
                    cnt_d   = '0;
                    state_d = SQB;
                end
            end
            SQB: begin
                acc_d = acc_q + (b_q[idx] ? (ACC_W'(b_q) << cnt_q) : '0);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_SQ) begin
                    cnt_d   = '0;
                    state_d = ROOT;
                end
            end
            ROOT: begin
                acc_d  = acc_q << 2;
                rem_d  = ge ? (rem_t - trial) : rem_t;
                root_d = {root_q[DATA_W-1:0], ge};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_RT) begin
                    y_d     = {root_q[DATA_W-1:0], ge};
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
        end
    end

    assign y    = y_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_sr_hypot_unit.sv
// tb_sr_hypot_unit: directed self-checking bench for sr_hypot_unit.
// Checks reset, results, latency, ignored start, abort and back-to-back jobs.
module tb_sr_hypot_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic [8:0] y;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    sr_hypot_unit #(.DATA_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a_i),
        .b    (b_i),
        .y    (y),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_job(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        start = 1'b1;
        a_i   = av;
        b_i   = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts busy-high negedges; returns at the first negedge with busy low.
    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_checks++;
        if (y !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_y: got %0d want 0", y);
        end
    endtask

    task automatic test_basic;
        int n;
        start_job(8'd3, 8'd4);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_rise: got %b want 1", busy);
        end
        n_checks++;
        if (y !== 9'd0) begin
            n_fail++;
            $display("FAIL basic_y_hold: got %0d want 0", y);
        end
        wait_done(n);
        n_checks++;
        if (n != 25) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want 25", n);
        end
        n_checks++;
        if (y !== 9'd5) begin
            n_fail++;
            $display("FAIL basic_y: got %0d want 5", y);
        end
    endtask

    task automatic test_vectors;
        logic [7:0] va [5] = '{8'd5, 8'd0, 8'd1, 8'd255, 8'd20};
        logic [7:0] vb [5] = '{8'd12, 8'd0, 8'd1, 8'd255, 8'd21};
        logic [8:0] vy [5] = '{9'd13, 9'd0, 9'd1, 9'd360, 9'd29};
        int n;
        for (int i = 0; i < 5; i++) begin
            start_job(va[i], vb[i]);
            wait_done(n);
            n_checks++;
            if (n != 25 || y !== vy[i]) begin
                n_fail++;
                $display("FAIL vec%0d: got y=%0d lat=%0d want y=%0d lat=25",
                         i, y, n, vy[i]);
            end
        end
    endtask

    task automatic test_y_stable;
        logic [8:0] prev;
        int         n;
        int         bad;
        prev = y;
        bad  = 0;
        start_job(8'd9, 8'd40);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                n++;
                if (y !== prev) bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL y_stable: got %0d changes want 0", bad);
        end
        n_checks++;
        if (y !== 9'd41) begin
            n_fail++;
            $display("FAIL y_stable_result: got %0d want 41", y);
        end
    endtask

    task automatic test_ignore_start;
        int n;
        start_job(8'd3, 8'd4);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
            if (n == 10) begin
                start = 1'b1;
                a_i   = 8'd7;
                b_i   = 8'd24;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++;
        if (n != 25) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d want 25", n);
        end
        n_checks++;
        if (y !== 9'd5) begin
            n_fail++;
            $display("FAIL ignore_y: got %0d want 5", y);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_no_restart: got %b want 0", busy);
        end
    endtask

    task automatic test_mid_reset;
        int n;
        start_job(8'd3, 8'd4);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || y !== 9'd0) begin
            n_fail++;
            $display("FAIL midreset_state: got busy=%b y=%0d want busy=0 y=0",
                     busy, y);
        end
        start_job(8'd6, 8'd8);
        wait_done(n);
        n_checks++;
        if (n != 25 || y !== 9'd10) begin
            n_fail++;
            $display("FAIL midreset_rerun: got y=%0d lat=%0d want y=10 lat=25",
                     y, n);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] va [4] = '{8'd3, 8'd5, 8'd8, 8'd100};
        logic [7:0] vb [4] = '{8'd4, 8'd12, 8'd15, 8'd0};
        logic [8:0] vy [3] = '{9'd5, 9'd13, 9'd17};
        int n;
        @(negedge clk);
        start = 1'b1;
        a_i   = va[0];
        b_i   = vb[0];
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_accept%0d: got busy=%b want 1", k, busy);
            end
            a_i = va[k+1];
            b_i = vb[k+1];
            if (k == 2) start = 1'b0;
            wait_done(n);
            n_checks++;
            if (n != 25 || y !== vy[k]) begin
                n_fail++;
                $display("FAIL b2b_job%0d: got y=%0d lat=%0d want y=%0d lat=25",
                         k, y, n, vy[k]);
            end
            if (k < 2) begin
                a_i = va[k+1];
                b_i = vb[k+1];
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_y_stable();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
